// File: rtl/lu_sweep_ctrl.sv
// lu_sweep_ctrl: latches an operand pair, sweeps the 4-bit logic unit through
// sel 0..3, packs the returned bits into a flag word and self-checks it.
module lu_sweep_ctrl #(
    parameter int unsigned OPW  = 4,
    parameter int unsigned CNTW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [OPW-1:0]  op_a,
    input  logic [OPW-1:0]  op_b,
    input  logic            lu_out,
    output logic [OPW-1:0]  lu_a,
    output logic [OPW-1:0]  lu_b,
    output logic [2:0]      lu_sel,
    output logic            busy,
    output logic [3:0]      flags,
    output logic            flags_valid,
    input  logic            flags_ack,
    output logic            chk_err,
    output logic [3:0]      err_mask,
    output logic [CNTW-1:0] sweep_cnt
);

    localparam int unsigned SELW  = 2;
    localparam int unsigned FLAGW = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [SELW-1:0]   sel_q, sel_d;
    logic [OPW-1:0]    lu_a_q, lu_a_d;
    logic [OPW-1:0]    lu_b_q, lu_b_d;
    logic              busy_q, busy_d;
    logic [FLAGW-1:0]  flags_q, flags_d;
    logic              flags_valid_q, flags_valid_d;
    logic              chk_err_q, chk_err_d;
    logic [FLAGW-1:0]  err_mask_q, err_mask_d;
    logic [CNTW-1:0]   sweep_cnt_q, sweep_cnt_d;

    logic [OPW:0]      sum_w;
    logic [FLAGW-1:0]  exp_flags;
    logic [FLAGW-1:0]  cap_flags;

    // Expected flag word from the latched operands, and the flag word with this cycle's LU bit merged in.
    always_comb begin
        sum_w     = {1'b0, lu_a_q} + {1'b0, lu_b_q};
        exp_flags = {sum_w[OPW], lu_b_q[0], lu_a_q[0], (lu_a_q <= lu_b_q)};
        cap_flags = flags_q;
        cap_flags[sel_q] = lu_out;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        lu_a_d        = lu_a_q;
        lu_b_d        = lu_b_q;
        busy_d        = busy_q;
        flags_d       = flags_q;
        flags_valid_d = flags_valid_q;
        chk_err_d     = chk_err_q;
        err_mask_d    = err_mask_q;
        sweep_cnt_d   = sweep_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    lu_a_d  = op_a;
                    lu_b_d  = op_b;
                    sel_d   = SELW'(0);
                    busy_d  = 1'b1;
                    state_d = ST_SWEEP;
                end
            end
            ST_SWEEP: begin
                flags_d = cap_flags;
                sel_d   = sel_q + SELW'(1);
                if (sel_q == SELW'(3)) begin
                    flags_valid_d = 1'b1;
                    err_mask_d    = cap_flags ^ exp_flags;
                    chk_err_d     = |(cap_flags ^ exp_flags);
                    sweep_cnt_d   = sweep_cnt_q + CNTW'(1);
                    state_d       = ST_DONE;
                end
            end
            ST_DONE: begin
                // Ack wins over a coincident start; the start is dropped.
                if (flags_ack) begin
                    flags_valid_d = 1'b0;
                    busy_d        = 1'b0;
                    state_d       = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            sel_q         <= '0;
            lu_a_q        <= '0;
            lu_b_q        <= '0;
            busy_q        <= 1'b0;
            flags_q       <= '0;
            flags_valid_q <= 1'b0;
            chk_err_q     <= 1'b0;
            err_mask_q    <= '0;
            sweep_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            lu_a_q        <= lu_a_d;
            lu_b_q        <= lu_b_d;
            busy_q        <= busy_d;
            flags_q       <= flags_d;
            flags_valid_q <= flags_valid_d;
            chk_err_q     <= chk_err_d;
            err_mask_q    <= err_mask_d;
            sweep_cnt_q   <= sweep_cnt_d;
        end
    end

    // LU select decoded straight from flops: sel counter during SWEEP, else 0.
    always_comb begin
        lu_sel = 3'd0;
        if (state_q == ST_SWEEP) begin
            lu_sel = {1'b0, sel_q};
        end
    end

    assign lu_a        = lu_a_q;
    assign lu_b        = lu_b_q;
    assign busy        = busy_q;
    assign flags       = flags_q;
    assign flags_valid = flags_valid_q;
    assign chk_err     = chk_err_q;
    assign err_mask    = err_mask_q;
    assign sweep_cnt   = sweep_cnt_q;

endmodule
